// File: rtl/ahb_matrix_arbiter.sv
// ahb_matrix_arbiter: priority / round-robin AHB slave-port arbiter with
// burst locking. Optional starvation aging is compiled in only when the
// macro AHB_ARB_STARVE_EN is defined; the default build uses hprior as is.
module ahb_matrix_arbiter #(
  parameter int NUM_MASTERS  = 4,
  parameter int PRIOR_W      = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                           hclk,
  input  logic                           hreset_n,
  input  logic [NUM_MASTERS-1:0]         hreq,
  input  logic [NUM_MASTERS*PRIOR_W-1:0] hprior,
  input  logic [1:0]                     htrans,
  input  logic [2:0]                     hburst,
  input  logic                           hready,
  output logic [NUM_MASTERS-1:0]         hgrant,
  output logic [NUM_MASTERS-1:0]         hgrant_d,
  output logic                           hsel
);

  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  // Effective priority carries one extra MSB used as the starvation flag.
  localparam int EFF_W = PRIOR_W + 1;

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;
  localparam logic [2:0] BU_SINGLE = 3'd0;
  localparam logic [2:0] BU_INCR   = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BURST = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [NUM_MASTERS-1:0] gdata_q;
  logic [PTR_W-1:0]       rr_q, rr_d;
  logic [3:0]             beat_q, beat_d;
  logic                   incr_q, incr_d;

  logic [EFF_W-1:0]       eff_prio [NUM_MASTERS];
  logic [EFF_W-1:0]       best;
  logic                   win_vld;
  logic [PTR_W-1:0]       win_idx;
  int                     idx;
  logic                   arb_en;
  logic                   owner_req;

  // Remaining SEQ beats after the NONSEQ of a fixed-length burst.
  function automatic logic [3:0] beats_m1(input logic [2:0] burst);
    case (burst)
      3'd2, 3'd3: beats_m1 = 4'd3;
      3'd4, 3'd5: beats_m1 = 4'd7;
      3'd6, 3'd7: beats_m1 = 4'd15;
      default:    beats_m1 = 4'd0;
    endcase
  endfunction

  // While a master owns the bus the round-robin pointer holds its index.
  assign owner_req = hreq[rr_q];

`ifdef AHB_ARB_STARVE_EN
  logic [7:0]             age_q [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] starved;

  // Starved masters jump above every non-starved priority level.
  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      starved[i]  = (age_q[i] >= 8'(STARVE_LIMIT));
      eff_prio[i] = starved[i] ? {EFF_W{1'b1}}
                               : {1'b0, hprior[i*PRIOR_W +: PRIOR_W]};
    end
  end

  // Age counters: count lost arbitrations, clear on grant or dropped request.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      for (int i = 0; i < NUM_MASTERS; i++) age_q[i] <= 8'd0;
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!hreq[i]) begin
          age_q[i] <= 8'd0;
        end else if (arb_en) begin
          if (win_vld && (win_idx == PTR_W'(i))) age_q[i] <= 8'd0;
          else if (age_q[i] != 8'hFF)            age_q[i] <= age_q[i] + 8'd1;
        end
      end
    end
  end
`else
  // Without aging the effective priority is the raw priority.
  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      eff_prio[i] = {1'b0, hprior[i*PRIOR_W +: PRIOR_W]};
    end
  end
`endif

  // Winner search: scan from pointer+1, strict '>' keeps the earliest tie.
  always_comb begin
    win_vld = 1'b0;
    win_idx = rr_q;
    best    = '0;
    idx     = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = int'(rr_q) + 1 + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (hreq[idx] && (!win_vld || (eff_prio[idx] > best))) begin
        win_vld = 1'b1;
        win_idx = PTR_W'(idx);
        best    = eff_prio[idx];
      end
    end
  end

  // Next state: burst locking, burst termination and arbitration points.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    incr_d  = incr_q;
    arb_en  = 1'b0;
    if (hready) begin
      case (state_q)
        ST_IDLE: arb_en = 1'b1;
        ST_GRANT: begin
          if (owner_req && (htrans == TR_NONSEQ) && (hburst != BU_SINGLE)) begin
            state_d = ST_BURST;
            incr_d  = (hburst == BU_INCR);
            beat_d  = (hburst == BU_INCR) ? 4'd0 : beats_m1(hburst);
          end else begin
            arb_en = 1'b1;
          end
        end
        ST_BURST: begin
          if (!owner_req || (htrans == TR_IDLE) || (htrans == TR_NONSEQ)) begin
            // Early termination or end of an undefined-length burst.
            arb_en = 1'b1;
          end else if ((htrans == TR_SEQ) && !incr_q) begin
            if (beat_q <= 4'd1) arb_en = 1'b1;
            else                beat_d = beat_q - 4'd1;
          end
        end
        default: arb_en = 1'b1;
      endcase

      if (arb_en) begin
        beat_d = 4'd0;
        incr_d = 1'b0;
        if (win_vld) begin
          state_d          = ST_GRANT;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          rr_d             = win_idx;
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
    end
  end

  // State registers; data-phase owner follows the address grant on hready.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gdata_q <= '0;
      rr_q    <= PTR_W'(NUM_MASTERS - 1);
      beat_q  <= 4'd0;
      incr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
      incr_q  <= incr_d;
      if (hready) gdata_q <= grant_q;
    end
  end

  assign hgrant   = grant_q;
  assign hgrant_d = gdata_q;
  assign hsel     = |grant_q;

endmodule
